// File: rtl/reg_view_ctrl.sv
// reg_view_ctrl: register-file viewer controller. Debounces next/prev
// buttons, steps or auto-scans a 5-bit index and reloads the display word.
// Ports:
//   clk       system clock, all state on rising edge
//   clr_n     asynchronous active-low clear
//   btn_next  raw button, steps index up
//   btn_prev  raw button, steps index down
//   auto_en   level, 1 = auto-scan mode
//   rd_addr   read address to register file (= disp_idx)
//   rd_data   combinational read data for rd_addr
//   disp_x    registered word for the hex display
//   disp_idx  registered index currently shown
//   upd       one-cycle pulse with each disp_x load
module reg_view_ctrl #(
    parameter int unsigned DEB_CYCLES     = 1000000,
    parameter int unsigned SCAN_CYCLES    = 100000000,
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        auto_en,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [31:0] disp_x,
    output logic [4:0]  disp_idx,
    output logic        upd
);

    localparam logic [23:0] DEB_LAST  = 24'(DEB_CYCLES - 1);
    localparam logic [31:0] SCAN_LAST = 32'(SCAN_CYCLES - 1);
    localparam logic [23:0] REF_LAST  = 24'(REFRESH_CYCLES - 1);

    typedef enum logic {IDLE, FETCH} state_e;

    // bit 0 = next, bit 1 = prev
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       lvl_q;
    logic [1:0]       lvl_d;
    logic [1:0][23:0] deb_cnt_q;
    logic [1:0][23:0] deb_cnt_d;
    logic [1:0]       step;

    logic [4:0]  idx_q;
    logic [4:0]  idx_d;
    logic [31:0] scan_q;
    logic [31:0] scan_d;
    logic        idx_chg;

    state_e      state_q;
    state_e      state_d;
    logic [23:0] ref_q;
    logic [23:0] ref_d;
    logic [31:0] disp_q;
    logic [31:0] disp_d;
    logic        upd_q;
    logic        upd_d;

    assign btn_raw = {btn_prev, btn_next};

    // Debounce: the level flips on the DEB_CYCLES-th consecutive cycle the
    // synchronized input differs from it; the step fires in that same cycle.
    always_comb begin
        lvl_d     = lvl_q;
        deb_cnt_d = '0;
        step      = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
                if (deb_cnt_q[b] == DEB_LAST) begin
                    lvl_d[b] = sync2_q[b];
                    step[b]  = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 24'd1;
                end
            end
        end
    end

    // Index: auto-scan owns the index while auto_en is high.
    always_comb begin
        idx_d  = idx_q;
        scan_d = '0;
        if (auto_en) begin
            if (scan_q == SCAN_LAST) begin
                idx_d = idx_q + 5'd1;
            end else begin
                scan_d = scan_q + 32'd1;
            end
        end else begin
            unique case (step)
                2'b01:   idx_d = idx_q + 5'd1;
                2'b10:   idx_d = idx_q - 5'd1;
                default: idx_d = idx_q;
            endcase
        end
    end

    assign idx_chg = (idx_d != idx_q);

    // A change during FETCH re-arms FETCH so only the newest index loads.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        disp_d  = disp_q;
        upd_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (idx_chg || ref_q == REF_LAST) begin
                    state_d = FETCH;
                    ref_d   = '0;
                end else begin
                    ref_d = ref_q + 24'd1;
                end
            end
            FETCH: begin
                ref_d = '0;
                if (!idx_chg) begin
                    disp_d  = rd_data;
                    upd_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            deb_cnt_q <= '0;
            idx_q     <= '0;
            scan_q    <= '0;
            state_q   <= FETCH;
            ref_q     <= '0;
            disp_q    <= '0;
            upd_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            deb_cnt_q <= deb_cnt_d;
            idx_q     <= idx_d;
            scan_q    <= scan_d;
            state_q   <= state_d;
            ref_q     <= ref_d;
            disp_q    <= disp_d;
            upd_q     <= upd_d;
        end
    end

    assign rd_addr  = idx_q;
    assign disp_idx = idx_q;
    assign disp_x   = disp_q;
    assign upd      = upd_q;

endmodule

// File: tb/tb_reg_view_ctrl.sv
// tb_reg_view_ctrl: directed plus randomized bench for reg_view_ctrl,
// compared cycle by cycle against an event-level reference model.
module tb_reg_view_ctrl;

    localparam int DEB  = 4;
    localparam int SCAN = 8;
    localparam int REF  = 16;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic        auto_en = 1'b0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] disp_x;
    logic [4:0]  disp_idx;
    logic        upd;

    logic [31:0] mem [32];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    reg_view_ctrl #(
        .DEB_CYCLES(DEB),
        .SCAN_CYCLES(SCAN),
        .REFRESH_CYCLES(REF)
    ) dut (
        .clk(clk),
        .clr_n(clr_n),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .auto_en(auto_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .disp_x(disp_x),
        .disp_idx(disp_idx),
        .upd(upd)
    );

    // Reference model state
    bit [1:0]     m_s1;
    bit [1:0]     m_s2;
    bit [1:0]     m_lvl;
    bit [DEB-1:0] m_hist [2];
    logic [4:0]   m_idx;
    logic [31:0]  m_disp;
    logic         m_upd;
    logic         m_due;
    int           m_age;
    int           m_idle;

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_lvl = '0;
        m_hist[0] = '0;
        m_hist[1] = '0;
        m_idx = '0;
        m_disp = '0;
        m_upd = 1'b0;
        m_due = 1'b1;
        m_age = 0;
        m_idle = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        bit [1:0]   rise;
        bit [1:0]   raw;
        logic [4:0] nidx;
        raw = {btn_prev, btn_next};
        rise = '0;
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = {m_hist[b][DEB-2:0], m_s2[b]};
            if (m_hist[b] == {DEB{~m_lvl[b]}}) begin
                m_lvl[b] = ~m_lvl[b];
                rise[b] = m_lvl[b];
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        nidx = m_idx;
        if (auto_en) begin
            m_age++;
            if (m_age % SCAN == 0) nidx = m_idx + 5'd1;
        end else begin
            m_age = 0;
            if (rise == 2'b01) nidx = m_idx + 5'd1;
            if (rise == 2'b10) nidx = m_idx - 5'd1;
        end
        m_upd = 1'b0;
        if (nidx != m_idx) begin
            m_due = 1'b1;
            m_idle = 0;
        end else if (m_due) begin
            m_disp = mem[m_idx];
            m_upd = 1'b1;
            m_due = 1'b0;
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == REF) begin
                m_due = 1'b1;
                m_idle = 0;
            end
        end
        m_idx = nidx;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (clr_n) model_step();
        @(negedge clk);
        chk("disp_x", disp_x, m_disp);
        chk("disp_idx", {27'd0, disp_idx}, {27'd0, m_idx});
        chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_idx});
        chk("upd", {31'd0, upd}, {31'd0, m_upd});
    endtask

    task automatic press(input logic n, input logic p, input int hold);
        btn_next = n;
        btn_prev = p;
        repeat (hold) cyc();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (8) cyc();
    endtask

    initial begin
        bit hit;
        int r;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
        model_reset();
        repeat (3) cyc();

        clr_n = 1'b1;
        cyc();
        chk("rst_disp_x", disp_x, 32'hA000_0000);
        chk("rst_upd", {31'd0, upd}, 32'd1);
        chk("rst_idx", {27'd0, disp_idx}, 32'd0);
        cyc();
        chk("rst_upd_low", {31'd0, upd}, 32'd0);

        btn_next = 1'b1;
        cyc();
        btn_next = 1'b0;
        cyc();
        btn_next = 1'b1;
        repeat (10) cyc();
        btn_next = 1'b0;
        repeat (8) cyc();
        chk("bounce_idx", {27'd0, disp_idx}, 32'd1);
        chk("bounce_x", disp_x, 32'hA000_0001);

        press(1'b0, 1'b1, 8);
        press(1'b0, 1'b1, 8);
        chk("prev_wrap_idx", {27'd0, disp_idx}, 32'd31);
        chk("prev_wrap_x", disp_x, 32'hA000_001F);

        press(1'b1, 1'b1, 8);
        chk("both_idx", {27'd0, disp_idx}, 32'd31);

        press(1'b0, 1'b1, 8);
        chk("at30_idx", {27'd0, disp_idx}, 32'd30);

        auto_en = 1'b1;
        btn_next = 1'b1;
        repeat (6) cyc();
        btn_next = 1'b0;
        repeat (2) cyc();
        chk("auto_8", {27'd0, disp_idx}, 32'd31);
        repeat (8) cyc();
        chk("auto_16", {27'd0, disp_idx}, 32'd0);
        auto_en = 1'b0;
        repeat (4) cyc();
        chk("auto_off_idx", {27'd0, disp_idx}, 32'd0);

        mem[0] = 32'h1234_5678;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cyc();
            if (upd) hit = 1'b1;
        end
        chk("refresh_seen", {31'd0, hit}, 32'd1);
        chk("refresh_x", disp_x, 32'h1234_5678);

        btn_next = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc();
            if (m_due && m_idx != 5'd0) hit = 1'b1;
        end
        chk("fetch_reached", {31'd0, hit}, 32'd1);
        btn_next = 1'b0;
        clr_n = 1'b0;
        model_reset();
        #1;
        chk("clr_x", disp_x, 32'd0);
        chk("clr_idx", {27'd0, disp_idx}, 32'd0);
        chk("clr_upd", {31'd0, upd}, 32'd0);
        mem[0] = 32'hA000_0000;
        repeat (2) cyc();
        clr_n = 1'b1;
        cyc();
        chk("reload_x", disp_x, 32'hA000_0000);
        chk("reload_upd", {31'd0, upd}, 32'd1);

        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 99);
            btn_next = 1'($urandom_range(0, 1));
            btn_prev = 1'($urandom_range(0, 1));
            if (r < 12) auto_en = ~auto_en;
            if (r >= 12 && r < 25) mem[$urandom_range(0, 31)] = $urandom();
            if (r == 99) begin
                clr_n = 1'b0;
                model_reset();
                cyc();
                clr_n = 1'b1;
            end
            repeat ($urandom_range(1, 10)) cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_view_ctrl.md
REG_VIEW_CTRL -- requirements
Module: reg_view_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, is the consecutive stable cycles a button needs to be accepted (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter SCAN_CYCLES, default 100000000, is the auto-scan dwell per register in cycles; legal range 2..2^32-1.
REQ-003 Parameter REFRESH_CYCLES, default 1000000, is the idle re-read period of the current register in cycles; legal range 2..2^24-1.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 clr_n  in  1  asynchronous active-low reset; assertion clears all state immediately.
REQ-006 btn_next  in  1  raw asynchronous push-button; a press steps the index up.
REQ-007 btn_prev  in  1  raw asynchronous push-button; a press steps the index down.
REQ-008 auto_en  in  1  level-sensitive; 1 selects auto-scan mode.
REQ-009 rd_addr  out  5  read address to the register file's asynchronous read port; equals disp_idx.
REQ-010 rd_data  in  32  combinational read data returned for rd_addr.
REQ-011 disp_x  out  32  registered word sent to the 8-digit hex display driver.
REQ-012 disp_idx  out  5  registered index of the register currently shown.
REQ-013 upd  out  1  one-cycle pulse, coincident with each disp_x load.

Function
REQ-014 Each button passes through a 2-flop synchronizer before any other logic.
REQ-015 Debounce: the debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count at 0.
REQ-016 Step pulse: one cycle on each 0->1 transition of a debounced level; holding a button yields exactly one step.
REQ-017 Manual mode (auto_en=0): next step gives idx+1 mod 32; prev step gives idx-1 mod 32; 31->0 and 0->31 wrap; both steps in the same cycle leave idx unchanged and start no fetch.
REQ-018 Auto mode (auto_en=1): button steps are ignored; the scan counter counts 0..SCAN_CYCLES-1, and on reaching SCAN_CYCLES-1 it returns to 0 and idx advances +1 mod 32.
REQ-019 The scan counter is held at 0 while auto_en=0, so the first auto advance occurs SCAN_CYCLES cycles after auto_en rises.
REQ-020 FSM states: IDLE and FETCH.
REQ-021 Any idx change moves the FSM to FETCH, or keeps it in FETCH if already there.
REQ-022 FETCH lasts one cycle with rd_addr equal to the new idx; at the end of that cycle disp_x <= rd_data and upd=1 for the following cycle; the FSM then enters IDLE.
REQ-023 Latency: a step pulse in cycle n updates idx at the end of n, occupies FETCH during n+1, and has disp_x/upd valid in n+2.
REQ-024 A new idx change during FETCH restarts FETCH with the newest idx; only the newest value is loaded, and upd fires once.
REQ-025 IDLE refresh: the refresh counter counts IDLE cycles; at REFRESH_CYCLES-1 it clears and the FSM enters FETCH for the same idx, so register-file writes appear on the display; it clears on every entry to FETCH.
REQ-026 upd is never high for two consecutive cycles.
REQ-027 A change of auto_en does not itself alter idx or disp_x.

Reset
REQ-028 On clr_n=0: idx=0, disp_idx=0, rd_addr=0, disp_x=0, upd=0; all counters, synchronizers and debounced levels are 0.
REQ-029 The FSM resets to FETCH, so the first rising edge after clr_n deasserts loads register 0 and pulses upd.
REQ-030 Reset asserted mid-FETCH or mid-debounce aborts it; no partial load or step occurs.

Verification
REQ-031 Benches use DEB_CYCLES=4, SCAN_CYCLES=8, REFRESH_CYCLES=16, with a register-file model where rd_data = 32'hA0000000 + addr.
REQ-032 Release reset -> after one edge, disp_x=A0000000, upd=1 for one cycle, disp_idx=0.
REQ-033 btn_next bounces 1,0,1 then holds 1 for 10 cycles -> exactly one step; disp_idx=1 and disp_x=A0000001 in the cycle 2 cycles after the step pulse.
REQ-034 btn_prev press at idx=0 -> disp_idx=31, disp_x=A000001F; both buttons accepted in the same cycle -> idx unchanged, no upd.
REQ-035 auto_en=1 at idx=30 -> idx 31 after 8 cycles, then 0 after 16; button presses are ignored; upd count equals the number of advances plus the number of refreshes.
REQ-036 Idle 16 cycles with the model word for idx changed to 12345678 -> refresh fetch, disp_x=12345678, upd=1; clr_n pulsed mid-FETCH -> all outputs 0 during reset, then register 0 reloads.
